// File: rtl/whack_game_core.sv
// Whack-a-mole game engine: idle -> countdown -> timed round -> game over, LFSR mole draw, scoring, high score.
// Latency: start/switch rising edges take effect at the next clk edge; every output is a register.
// Backpressure: none; inputs are sampled every cycle and the engine never stalls.
module whack_game_core #(
    parameter int N_MOLES  = 5,
    parameter int SCORE_W  = 8,
    parameter int TICK_DIV = 100_000_000,
    parameter int COUNT_S  = 5,
    parameter int ROUND_S  = 30,
    parameter int LVL_W    = 2,
    parameter int PENALTY  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LVL_W-1:0]   level_select,
    input  logic [N_MOLES-1:0] switch_in,
    output logic [N_MOLES-1:0] mole_led,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic [7:0]         time_left,
    output logic [1:0]         phase
);

    // Counter widths: both tick counters count below TICK_DIV; lane index covers N_MOLES lanes.
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int LANE_W = $clog2(N_MOLES);

    localparam logic [CNT_W:0]     TICK_V    = (CNT_W+1)'(TICK_DIV);
    localparam logic [CNT_W:0]     ONE_W     = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0]   SEC_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;
    localparam logic [15:0]        LFSR_TAPS = 16'hB400;   // x^16+x^14+x^13+x^11+1, right-shifting Galois form
    localparam logic [7:0]         N_V       = 8'(N_MOLES);
    localparam logic [LANE_W-1:0]  LANE_LAST = LANE_W'(N_MOLES - 1);
    localparam logic [LANE_W-1:0]  LANE_ONE  = LANE_W'(1);
    localparam logic [N_MOLES-1:0] LANE0_BIT = N_MOLES'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COUNTDOWN = 2'b01,
        PLAY      = 2'b10,
        OVER      = 2'b11
    } state_t;

    state_t state_q, state_nx;

    // Registered state besides the FSM and the outputs
    logic                  start_q;
    logic [N_MOLES-1:0]    sw_q;
    logic [15:0]           lfsr;
    logic [CNT_W-1:0]      sec_cnt, sec_cnt_nx;
    logic [CNT_W-1:0]      mole_cnt, mole_cnt_nx;
    logic [LVL_W-1:0]      lvl, lvl_nx;
    logic [LANE_W-1:0]     prev_lane, prev_nx;

    // Next values of the output registers
    logic [N_MOLES-1:0]    led_nx;
    logic [SCORE_W-1:0]    score_nx, high_nx;
    logic                  new_high_nx;
    logic [7:0]            time_nx;

    // Combinational helpers
    logic                  st_edge;
    logic [N_MOLES-1:0]    sw_edge;
    logic                  sec_tick, mole_tick;
    logic [CNT_W:0]        mole_per, mole_last;
    logic                  hit, miss;
    logic [SCORE_W-1:0]    score_adj;
    logic [15:0]           lfsr_nx;
    logic [LANE_W-1:0]     idx, draw_prev, draw_lane;
    logic [N_MOLES-1:0]    draw_onehot;

    assign phase = state_q;

    // Edge detection, time bases, hit/miss scoring and the candidate mole for this cycle
    always_comb begin
        st_edge   = start & ~start_q;
        sw_edge   = switch_in & ~sw_q;
        sec_tick  = ((state_q == COUNTDOWN) || (state_q == PLAY)) && (sec_cnt == SEC_LAST);
        mole_per  = TICK_V >> lvl;
        mole_last = mole_per - ONE_W;
        mole_tick = (state_q == PLAY) && ({1'b0, mole_cnt} == mole_last);

        hit  = |(sw_edge & mole_led);
        miss = (PENALTY != 0) && (|(sw_edge & ~mole_led));

        // A simultaneous hit and miss cancel; both ends saturate.
        score_adj = score;
        if (hit && !miss && (score != SCORE_MAX)) begin
            score_adj = score + SCORE_ONE;
        end else if (miss && !hit && (score != '0)) begin
            score_adj = score - SCORE_ONE;
        end

        lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

        // The first draw of a round treats lane 0 as the previous lane.
        idx       = LANE_W'(lfsr[7:0] % N_V);
        draw_prev = (state_q == PLAY) ? prev_lane : '0;
        if (idx == draw_prev) begin
            draw_lane = (idx == LANE_LAST) ? '0 : idx + LANE_ONE;
        end else begin
            draw_lane = idx;
        end
        draw_onehot = LANE0_BIT << draw_lane;
    end

    // Next-state and next-output logic for the game sequence
    always_comb begin
        state_nx    = state_q;
        sec_cnt_nx  = sec_cnt;
        mole_cnt_nx = mole_cnt;
        lvl_nx      = lvl;
        prev_nx     = prev_lane;
        led_nx      = mole_led;
        score_nx    = score;
        high_nx     = high_score;
        new_high_nx = new_high;
        time_nx     = time_left;

        case (state_q)
            IDLE, OVER: begin
                if (st_edge) begin
                    state_nx    = COUNTDOWN;
                    time_nx     = 8'(COUNT_S);
                    score_nx    = '0;
                    lvl_nx      = level_select;
                    sec_cnt_nx  = '0;
                    new_high_nx = 1'b0;
                end
            end

            COUNTDOWN: begin
                sec_cnt_nx = sec_tick ? '0 : sec_cnt + CNT_ONE;
                if (sec_tick) begin
                    if (time_left == 8'd1) begin
                        state_nx    = PLAY;
                        time_nx     = 8'(ROUND_S);
                        sec_cnt_nx  = '0;
                        mole_cnt_nx = '0;
                        led_nx      = draw_onehot;
                        prev_nx     = draw_lane;
                    end else begin
                        time_nx = time_left - 8'd1;
                    end
                end
            end

            PLAY: begin
                sec_cnt_nx  = sec_tick ? '0 : sec_cnt + CNT_ONE;
                mole_cnt_nx = mole_tick ? '0 : mole_cnt + CNT_ONE;
                score_nx    = score_adj;
                if (sec_tick && (time_left == 8'd1)) begin
                    // Final tick: the last-cycle score counts toward the high score.
                    state_nx = OVER;
                    time_nx  = '0;
                    led_nx   = '0;
                    if (score_adj > high_score) begin
                        high_nx     = score_adj;
                        new_high_nx = 1'b1;
                    end
                end else begin
                    if (sec_tick) begin
                        time_nx = time_left - 8'd1;
                    end
                    if (mole_tick) begin
                        led_nx  = draw_onehot;
                        prev_nx = draw_lane;
                    end else if (hit) begin
                        led_nx = '0;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Datapath and output registers; the edge registers reset high so held inputs do not fire
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_q    <= 1'b1;
            sw_q       <= '1;
            lfsr       <= LFSR_SEED;
            sec_cnt    <= '0;
            mole_cnt   <= '0;
            lvl        <= '0;
            prev_lane  <= '0;
            mole_led   <= '0;
            score      <= '0;
            high_score <= '0;
            new_high   <= 1'b0;
            time_left  <= '0;
        end else begin
            start_q    <= start;
            sw_q       <= switch_in;
            lfsr       <= lfsr_nx;
            sec_cnt    <= sec_cnt_nx;
            mole_cnt   <= mole_cnt_nx;
            lvl        <= lvl_nx;
            prev_lane  <= prev_nx;
            mole_led   <= led_nx;
            score      <= score_nx;
            high_score <= high_nx;
            new_high   <= new_high_nx;
            time_left  <= time_nx;
        end
    end

endmodule

// File: tb/tb_whack_game_core.sv
// Bench for whack_game_core: two instances (8-bit score with penalty, 2-bit score without) share one stimulus.
// A game-level model predicts every cycle's outputs into queues; a negedge monitor pops and compares.
// Directed games cover reset, sequence timing, hits, penalty, saturation and high score; then random play.
module tb_whack_game_core;

    localparam int N  = 5;
    localparam int TD = 8;
    localparam int CS = 2;
    localparam int RS = 3;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] level_select;
    logic [N-1:0]  switch_in;

    logic [N-1:0]  a_led,  b_led;
    logic [7:0]    a_score, a_high;
    logic [1:0]    b_score, b_high;
    logic          a_nh, b_nh;
    logic [7:0]    a_tl, b_tl;
    logic [1:0]    a_ph, b_ph;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    whack_game_core #(.N_MOLES(N), .SCORE_W(8), .TICK_DIV(TD), .COUNT_S(CS), .ROUND_S(RS),
                      .LVL_W(LW), .PENALTY(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .level_select(level_select), .switch_in(switch_in),
        .mole_led(a_led), .score(a_score), .high_score(a_high), .new_high(a_nh),
        .time_left(a_tl), .phase(a_ph));

    whack_game_core #(.N_MOLES(N), .SCORE_W(2), .TICK_DIV(TD), .COUNT_S(CS), .ROUND_S(RS),
                      .LVL_W(LW), .PENALTY(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .level_select(level_select), .switch_in(switch_in),
        .mole_led(b_led), .score(b_score), .high_score(b_high), .new_high(b_nh),
        .time_left(b_tl), .phase(b_ph));

    typedef struct packed {
        logic [N-1:0] led;
        logic [7:0]   score;
        logic [7:0]   high;
        logic         nh;
        logic [7:0]   tl;
        logic [1:0]   ph;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];

    // Game-level model, one slot per instance. m_t counts cycles spent in the current phase.
    int           m_ph[2], m_t[2], m_tl[2], m_sc[2], m_hi[2], m_lv[2], m_led[2], m_prv[2], m_lf[2];
    bit           m_nh[2], m_sq[2];
    logic [N-1:0] m_swq[2];
    int           smax[2] = '{255, 3};
    int           pen[2]  = '{1, 0};

    function automatic logic [N-1:0] lane_bit(input int l);
        logic [N-1:0] one;
        one = N'(1);
        return one << l;
    endfunction

    task automatic draw(input int k);
        int idx;
        idx = (m_lf[k] & 255) % N;
        if (idx == m_prv[k]) idx = (idx + 1) % N;
        m_led[k] = idx;
        m_prv[k] = idx;
    endtask

    task automatic model_step(input int k, input bit rst_n, input bit st, input int lvsel,
                              input logic [N-1:0] sw);
        bit           st_e, hit, miss;
        logic [N-1:0] swe, ledm;
        int           p;
        if (!rst_n) begin
            m_ph[k] = 0; m_t[k] = 0; m_tl[k] = 0; m_sc[k] = 0; m_hi[k] = 0; m_nh[k] = 0;
            m_lv[k] = 0; m_led[k] = -1; m_prv[k] = 0; m_lf[k] = 'hACE1; m_sq[k] = 1; m_swq[k] = '1;
            return;
        end
        st_e = st && !m_sq[k];
        swe  = sw & ~m_swq[k];
        ledm = (m_led[k] < 0) ? '0 : lane_bit(m_led[k]);
        case (m_ph[k])
            0, 3: if (st_e) begin
                m_ph[k] = 1; m_t[k] = 0; m_tl[k] = CS; m_sc[k] = 0; m_lv[k] = lvsel; m_nh[k] = 0;
            end
            1: if (m_t[k] == CS * TD - 1) begin
                m_ph[k] = 2; m_t[k] = 0; m_tl[k] = RS; m_prv[k] = 0;
                draw(k);
            end else begin
                m_t[k]++;
                m_tl[k] = CS - m_t[k] / TD;
            end
            2: begin
                hit  = (swe & ledm) != '0;
                miss = (pen[k] != 0) && ((swe & ~ledm) != '0);
                if (hit && !miss && m_sc[k] < smax[k]) m_sc[k]++;
                if (miss && !hit && m_sc[k] > 0) m_sc[k]--;
                if (m_t[k] == RS * TD - 1) begin
                    m_ph[k] = 3; m_tl[k] = 0; m_led[k] = -1;
                    if (m_sc[k] > m_hi[k]) begin
                        m_hi[k] = m_sc[k];
                        m_nh[k] = 1;
                    end
                end else begin
                    m_t[k]++;
                    m_tl[k] = RS - m_t[k] / TD;
                    p = TD >> m_lv[k];
                    if (m_t[k] % p == 0) draw(k);
                    else if (hit) m_led[k] = -1;
                end
            end
            default: ;
        endcase
        m_lf[k]  = (m_lf[k] >> 1) ^ (((m_lf[k] & 1) != 0) ? 'hB400 : 0);
        m_sq[k]  = st;
        m_swq[k] = sw;
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.led   = (m_led[k] < 0) ? '0 : lane_bit(m_led[k]);
        o.score = 8'(m_sc[k]);
        o.high  = 8'(m_hi[k]);
        o.nh    = m_nh[k];
        o.tl    = 8'(m_tl[k]);
        o.ph    = 2'(m_ph[k]);
        return o;
    endfunction

    // Predict each clock edge's outcome and queue it for the monitor
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k, reset, start, int'(level_select), switch_in);
        q_a.push_back(model_obs(0));
        q_b.push_back(model_obs(1));
    end

    task automatic compare_obs(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t got led=%b score=%0d high=%0d nh=%b tl=%0d ph=%0d expected led=%b score=%0d high=%0d nh=%b tl=%0d ph=%0d",
                     nm, $time, act.led, act.score, act.high, act.nh, act.tl, act.ph,
                     exp.led, exp.score, exp.high, exp.nh, exp.tl, exp.ph);
        end
    endtask

    // Monitor: compare both instances against the queued predictions away from the active edge
    always @(negedge clk) begin
        obs_t act;
        if (q_a.size() > 0) begin
            act = '{led: a_led, score: a_score, high: a_high, nh: a_nh, tl: a_tl, ph: a_ph};
            compare_obs("cycle_a", act, q_a.pop_front());
        end
        if (q_b.size() > 0) begin
            act = '{led: b_led, score: {6'b0, b_score}, high: {6'b0, b_high}, nh: b_nh, tl: b_tl, ph: b_ph};
            compare_obs("cycle_b", act, q_b.pop_front());
        end
    end

    task automatic check_val(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then wait for PLAY while counting the cycles the DUT shows COUNTDOWN
    task automatic begin_game(input int lvl, input bit check_len);
        int guard, cd;
        level_select = LW'(lvl);
        start = 1'b1;
        cyc();
        start = 1'b0;
        guard = 0;
        cd = 0;
        while (m_ph[0] != 2 && guard < 100) begin
            if (a_ph == 2'b01) cd++;
            cyc();
            guard++;
        end
        if (guard >= 100) check_val("timeout_to_play", guard, 0);
        if (check_len) check_val("countdown_len", cd, CS * TD);
    endtask

    // Play a whole round scoring exactly n_hits by pressing the lit lane
    task automatic play_round(input int n_hits);
        int got, guard, pl;
        got = 0; guard = 0; pl = 0;
        while (m_ph[0] == 2 && guard < 100) begin
            if (a_ph == 2'b10) pl++;
            if (got < n_hits && m_led[0] >= 0 && switch_in == '0) begin
                switch_in = lane_bit(m_led[0]);
                got++;
            end else begin
                switch_in = '0;
            end
            cyc();
            guard++;
        end
        switch_in = '0;
        check_val("round_len", pl, RS * TD);
        check_val("hits_landed", got, n_hits);
    endtask

    initial begin
        int guard, r, wrong;
        logic [N-1:0] lanes_seen;

        reset = 1'b0; start = 1'b1; level_select = '0; switch_in = '0;
        repeat (3) cyc();
        reset = 1'b1;
        repeat (5) cyc();
        check_val("held_start_no_game", int'(a_ph), 0);
        check_val("reset_score", int'(a_score), 0);
        check_val("reset_led", int'(a_led), 0);
        start = 1'b0;
        cyc();

        // Game 1: five hits at level 2 sets a new high score
        begin_game(2, 1'b1);
        play_round(5);
        check_val("g1_phase_over", int'(a_ph), 3);
        check_val("g1_high", int'(a_high), 5);
        check_val("g1_new_high", int'(a_nh), 1);
        check_val("g1_sat_b", int'(b_score), 3);

        // Game 2: a tie keeps the high score and does not flag it
        begin_game(2, 1'b0);
        play_round(5);
        check_val("g2_new_high", int'(a_nh), 0);
        check_val("g2_high", int'(a_high), 5);
        check_val("g2_new_high_b", int'(b_nh), 0);

        // Game 3: reset mid-round clears the high score
        begin_game(1, 1'b0);
        repeat (5) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        check_val("g3_high_cleared", int'(a_high), 0);
        check_val("g3_phase_idle", int'(a_ph), 0);

        // Game 4 at level 3 (new mole every cycle): penalty floor, hit plus miss, held switch
        begin_game(3, 1'b0);
        switch_in = lane_bit((m_led[0] + 1) % N);
        cyc();
        check_val("miss_at_zero", int'(a_score), 0);
        repeat (4) begin
            switch_in = '0;
            cyc();
            switch_in = lane_bit(m_led[0]);
            cyc();
        end
        check_val("four_hits", int'(a_score), 4);
        switch_in = '0;
        cyc();
        wrong = (m_led[0] + 1) % N;
        switch_in = lane_bit(m_led[0]) | lane_bit(wrong);
        cyc();
        check_val("hit_plus_miss", int'(a_score), 4);
        repeat (3) cyc();
        check_val("held_no_rescore", int'(a_score), 4);
        switch_in = '0;
        guard = 0;
        while (m_ph[0] == 2 && guard < 100) begin
            cyc();
            guard++;
        end
        check_val("g4_over", int'(a_ph), 3);

        // Random play: starts, levels, aimed and stray presses, rare resets
        lanes_seen = '0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) switch_in = '0;
            else if (r <= 6) begin
                if (m_led[0] >= 0) switch_in = lane_bit(m_led[0]);
            end else if (r <= 8) switch_in = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 15) == 0) start = ~start;
            level_select = LW'($urandom_range(0, 3));
            reset = ($urandom_range(0, 399) != 0);
            cyc();
            lanes_seen |= a_led;
        end
        check_val("all_lanes_drawn", int'(lanes_seen), (1 << N) - 1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/whack_game_core.md
# whack_game_core

Parametrised game engine for the whack-a-mole design. It runs the complete game sequence as a four-state machine on a single clock: idle, start countdown, timed round, then game over. Moles are drawn pseudo-randomly across `N_MOLES` lanes with selectable speed levels, and the engine scores hits with an optional miss penalty and keeps a high-score register. It sits between the debounced switch inputs and the BCD/display path, and all time bases are clock enables derived internally.

## Interface
- `N_MOLES`, 5, number of mole lanes (LEDs/switches), 2..16
- `SCORE_W`, 8, width of score and high score
- `TICK_DIV`, 100_000_000, clk cycles per one-second tick, ≥ 2^`LVL_W`
- `COUNT_S`, 5, countdown length in seconds, 1..255
- `ROUND_S`, 30, round length in seconds, 1..255
- `LVL_W`, 2, width of `level_select`
- `PENALTY`, 1, 1 = each miss event subtracts one point, 0 = misses ignored
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: start request; only a rising edge acts.
- `level_select` input `LVL_W`: speed level, latched at game start.
- `switch_in` input `N_MOLES`: debounced, clk-synchronous switches.
- `mole_led` output `N_MOLES`: one-hot lit mole, or all zero.
- `score` output `SCORE_W`: current score.
- `high_score` output `SCORE_W`: best score since reset.
- `new_high` output 1: high while in OVER if the game set a new high score.
- `time_left` output 8: seconds remaining in COUNTDOWN or PLAY.
- `phase` output 2: 00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 OVER.

## Operation
- **Reset (`reset`=0 at a clk edge):**
  - State goes to IDLE.
  - All outputs go to 0, including `high_score`.
  - The LFSR loads 16'hACE1.
  - The start edge register loads 1, so a start held through reset does not trigger a game.
  - The switch edge register loads all-ones.
  - Reset mid-game aborts the game immediately.
- **Edge detect:**
  - `st_edge = start & ~start_q`.
  - `sw_edge = switch_in & ~sw_q`.
  - Both `start_q` and `sw_q` register their inputs every cycle.
- **LFSR:**
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state.
- **IDLE:**
  - `st_edge` moves to COUNTDOWN.
  - On that transition: `time_left`=COUNT_S, `score`=0, level latched into `lvl`, second counter cleared.
- **COUNTDOWN:**
  - Each second tick decrements `time_left`.
  - The tick taken with `time_left`==1 moves to PLAY.
  - On that transition: `time_left`=ROUND_S, second and mole counters cleared, first mole drawn.
- **PLAY, mole draw:**
  - Drawn on PLAY entry and on every mole tick.
  - `idx = lfsr[7:0] mod N_MOLES`.
  - If `idx` equals the previously lit lane, use `(idx+1) mod N_MOLES` instead.
  - "Previously lit lane" still applies after a hit cleared the LED; it is reset to lane 0 at PLAY entry.
  - `mole_led` becomes one-hot at the drawn lane.
- **PLAY, scoring:**
  - hit = `|(sw_edge & mole_led)`.
  - miss = `PENALTY & |(sw_edge & ~mole_led)`.
  - A hit clears `mole_led` to 0 until the next mole tick.
  - Per cycle, `score` += hit − miss.
  - Saturates at 2^SCORE_W−1 and at 0.
  - Any number of wrong switches in one cycle counts as one miss.
  - A hit and a miss in the same cycle net to 0.
- **PLAY, time:**
  - Each second tick decrements `time_left`.
  - The tick with `time_left`==1 moves to OVER.
  - On that transition: `mole_led`=0 and `time_left`=0.
  - A switch edge in the same cycle as the final tick is still scored.
  - A mole tick coinciding with the final tick draws nothing.
- **OVER:**
  - `score` is held.
  - On the entry edge, if the final score (including any last-cycle update) > `high_score`:
    - `high_score` takes that final score in the same edge.
    - `new_high` is set.
  - A tie does not set `new_high`.
  - `st_edge` moves to COUNTDOWN as in IDLE and clears `new_high`.
- `start` edges in COUNTDOWN and PLAY are ignored.
- Switch edges outside PLAY are ignored.

## Timing
- **Second tick:**
  - Counter runs 0..TICK_DIV−1 and is active in COUNTDOWN and PLAY.
  - Tick fires in the cycle the counter equals TICK_DIV−1.
  - COUNTDOWN lasts exactly COUNT_S·TICK_DIV cycles; PLAY lasts exactly ROUND_S·TICK_DIV cycles.
- **Mole tick:**
  - Period P = TICK_DIV >> `lvl`, using integer truncation.
  - Counter runs 0..P−1, is cleared on PLAY entry, and fires at P−1.
- **Latencies:**
  - `switch_in` rising in cycle n → `score`/`mole_led` updated at the edge ending cycle n, visible in cycle n+1.
  - `st_edge` in cycle n → `phase`=01 in cycle n+1.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Held switch:** a switch held high scores once; it must fall and rise again to score again.

## Test plan
Unless stated, the bench uses `TICK_DIV`=8, `COUNT_S`=2, `ROUND_S`=3, `N_MOLES`=5, `LVL_W`=2.

- **Reset:** hold `reset`=0 with `start`=1, release → all outputs 0, `phase`=00; no game starts until `start` falls and rises again.
- **Sequence:** pulse `start` → `phase`=01 for exactly 16 cycles with `time_left` 2,1, then `phase`=10 with `time_left`=3 for 24 cycles, then `phase`=11.
- **Hit and lockout:** in PLAY, raise the lit lane's switch → `score`=1 next cycle, `mole_led`=0; hold the switch → no further increment.
- **Penalty and saturation:**
  - Wrong switch at `score`=0 → `score` stays 0.
  - Hit plus wrong switch in the same cycle at `score`=4 → stays 4.
  - With `SCORE_W`=2 at 3, a hit → stays 3.
- **Level and draw:** `level_select`=2 → a new mole every 2 cycles, always one-hot, never the same lane twice in a row; 200 draws cover all 5 lanes.
- **High score:**
  - Game 1 ends at 5 → `high_score`=5, `new_high`=1.
  - Game 2 ends at 5 → `new_high`=0, `high_score`=5.
  - Reset mid-game 3 → `high_score`=0.
